seg_scan_mux: RTL

//  Upstream stage of the per-digit SevenSeg decoder: time-multiplexes a DIGITS-wide
//  hex value onto one shared decoder input and drives a one-hot digit enable.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_scan_timer.sv | 81 ++++++++
 rtl/seg_scan_mux.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and sizing helpers for the seven-segment scan multiplexer.
package seg_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_width(input int digits);
    return cnt_width(digits);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan sequencer: BLANK/SHOW dwell counter, digit index and frame tick.
// Exposes next-cycle state so the top can register outputs valid on entry to SHOW.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  localparam int IDX_W    = idx_width(DIGITS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_show_next,
  output logic [IDX_W-1:0] o_idx_next,
  output logic             o_frame_start,
  output logic             o_frame_tick
);

  localparam int CNT_W = (cnt_width(SCAN_DIV) > cnt_width(BLANK_CYC)) ?
                         cnt_width(SCAN_DIV) : cnt_width(BLANK_CYC);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t      r_state;
  scan_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_frame_start;
  logic             r_frame_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_frame_tick <= w_frame_start;
    end
  end

  // A frame starts on the BLANK->SHOW edge of digit 0.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + 1'b1;
    w_idx_next    = r_idx;
    w_frame_start = 1'b0;
    case (r_state)
      BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_next  = SHOW;
          w_cnt_next    = '0;
          w_frame_start = (r_idx == '0);
        end
      end
      SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_state_next = BLANK;
          w_cnt_next   = '0;
          w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = BLANK;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_show_next   = (w_state_next == SHOW);
  assign o_idx_next    = w_idx_next;
  assign o_frame_start = w_frame_start;
  assign o_frame_tick  = r_frame_tick;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes a DIGITS-wide hex value onto one shared SevenSeg nibble input,
// with dead time between digits, tear-free frame-boundary capture and leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NIB_W*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]       dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [NIB_W-1:0]        digit_nib,
  output logic [DIGITS-1:0]       digit_en,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int IDX_W = idx_width(DIGITS);

  logic                    w_show_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic                    w_frame_start;
  logic                    w_frame_tick;

  logic [NIB_W*DIGITS-1:0] r_staging_nib;
  logic [DIGITS-1:0]       r_staging_dp;
  logic                    r_pending;
  logic [NIB_W*DIGITS-1:0] r_shadow_nib;
  logic [DIGITS-1:0]       r_shadow_dp;
  logic [NIB_W*DIGITS-1:0] w_shadow_nib_next;
  logic [DIGITS-1:0]       w_shadow_dp_next;

  logic [DIGITS-1:0]       w_lead_zero;
  logic [NIB_W-1:0]        w_sel_nib;
  logic                    w_sel_dp;
  logic [DIGITS-1:0]       w_sel_en;
  logic                    w_sel_dark;

  logic [NIB_W-1:0]        r_digit_nib;
  logic [DIGITS-1:0]       r_digit_en;
  logic                    r_dp_out;

  seg_scan_timer #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_show_next   (w_show_next),
    .o_idx_next    (w_idx_next),
    .o_frame_start (w_frame_start),
    .o_frame_tick  (w_frame_tick)
  );

  // A load arriving on the boundary edge bypasses staging so it shows this frame.
  always_comb begin
    w_shadow_nib_next = r_shadow_nib;
    w_shadow_dp_next  = r_shadow_dp;
    if (w_frame_start) begin
      if (load) begin
        w_shadow_nib_next = value;
        w_shadow_dp_next  = dp_in;
      end else if (r_pending) begin
        w_shadow_nib_next = r_staging_nib;
        w_shadow_dp_next  = r_staging_dp;
      end
    end
  end

  // w_lead_zero[i]: every digit from the top down to i is blank (nibble 0, no dp).
  always_comb begin
    logic v_run;
    v_run       = 1'b1;
    w_lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_run = v_run && (w_shadow_nib_next[i*NIB_W +: NIB_W] == '0) && !w_shadow_dp_next[i];
      w_lead_zero[i] = v_run;
    end
  end

  always_comb begin
    w_sel_nib  = '0;
    w_sel_dp   = 1'b0;
    w_sel_en   = '0;
    w_sel_dark = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_next == IDX_W'(i)) begin
        w_sel_nib   = w_shadow_nib_next[i*NIB_W +: NIB_W];
        w_sel_dp    = w_shadow_dp_next[i];
        w_sel_en[i] = 1'b1;
        w_sel_dark  = (i != 0) && lz_en && w_lead_zero[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_staging_nib <= '0;
      r_staging_dp  <= '0;
      r_pending     <= 1'b0;
      r_shadow_nib  <= '0;
      r_shadow_dp   <= '0;
      r_digit_nib   <= '0;
      r_digit_en    <= '0;
      r_dp_out      <= 1'b0;
    end else begin
      if (load) begin
        r_staging_nib <= value;
        r_staging_dp  <= dp_in;
      end
      r_pending    <= w_frame_start ? 1'b0 : (r_pending | load);
      r_shadow_nib <= w_shadow_nib_next;
      r_shadow_dp  <= w_shadow_dp_next;
      if (w_show_next) begin
        r_digit_nib <= w_sel_nib;
        r_digit_en  <= w_sel_dark ? '0 : w_sel_en;
        r_dp_out    <= w_sel_dp && !w_sel_dark;
      end else begin
        r_digit_en <= '0;
        r_dp_out   <= 1'b0;
      end
    end
  end

  assign digit_nib  = r_digit_nib;
  assign digit_en   = r_digit_en;
  assign dp_out     = r_dp_out;
  assign frame_tick = w_frame_tick;

endmodule
